cbd_sampler_ctrl: RTL and testbench

Sequencer that turns a stream of 32-bit random words into a polynomial of centered-binomial coefficients. It reuses the shared `cbd` datapath by stepping its `funct7` mode field through CBD2_1..CBD2_8 (eta=2) or CBD3_1..CBD3_4 (eta=3) for each latched word. It reduces each signed result into [0, Q) and emits one coefficient per cycle on a valid/ready stream. It sits between the randomness source (SHAKE/PRF buffer) and the polynomial memory writer in the athos accelerator.

---
 rtl/athos_pkg.sv | 16 +
 rtl/cbd_sampler_ctrl_if.sv | 43 ++++
 rtl/cbd_sampler_ctrl.sv | 128 ++++++++++++
 tb/tb_cbd_sampler_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/athos_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : athos_pkg
//  Brief    : Shared types and cbd funct7 mode codes for the athos accelerator.
//  Revision : 1.0
// ============================================================================
package athos_pkg;

    typedef logic [6:0] funct7_t;

    // Modes within a family are consecutive, so slot k is BASE + k.
    localparam funct7_t CBD2_1 = 7'h20;
    localparam funct7_t CBD3_1 = 7'h28;

endpackage
`default_nettype wire

// File: rtl/cbd_sampler_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : cbd_sampler_ctrl_if
//  Brief    : Control, word-stream, cbd-operand and coefficient-stream bundle.
//  Revision : 1.0
// ============================================================================
interface cbd_sampler_ctrl_if #(
    parameter int N_COEFFS = 256,
    parameter int COEFF_W  = 12
);
    localparam int IDX_W = $clog2(N_COEFFS);

    logic                   start_i;
    logic                   eta3_i;
    logic                   clear_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   word_valid_i;
    logic                   word_ready_o;
    logic [31:0]            word_i;
    athos_pkg::funct7_t     cbd_mode_o;
    logic [31:0]            cbd_data_o;
    logic [31:0]            cbd_res_i;
    logic                   coef_valid_o;
    logic                   coef_ready_i;
    logic [COEFF_W-1:0]     coef_o;
    logic [IDX_W-1:0]       coef_idx_o;

    // Controller side; names are relative to the controller.
    modport slave (
        input  start_i, eta3_i, clear_i, word_valid_i, word_i, cbd_res_i, coef_ready_i,
        output busy_o, done_o, word_ready_o, cbd_mode_o, cbd_data_o,
               coef_valid_o, coef_o, coef_idx_o
    );

    modport master (
        output start_i, eta3_i, clear_i, word_valid_i, word_i, cbd_res_i, coef_ready_i,
        input  busy_o, done_o, word_ready_o, cbd_mode_o, cbd_data_o,
               coef_valid_o, coef_o, coef_idx_o
    );

endinterface
`default_nettype wire

// File: rtl/cbd_sampler_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cbd_sampler_ctrl
//  Brief    : Steps the shared cbd datapath over latched random words and
//             streams reduced centered-binomial coefficients.
//  Revision : 1.0
// ============================================================================
module cbd_sampler_ctrl #(
    parameter int N_COEFFS = 256,
    parameter int Q        = 3329,
    parameter int COEFF_W  = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    cbd_sampler_ctrl_if.slave       ctrl_if
);
    localparam int                IDX_W    = $clog2(N_COEFFS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_COEFFS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               eta3_q, eta3_d;
    logic [31:0]        word_q, word_d;
    logic [2:0]         sub_q, sub_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               w_last_slot;
    logic [31:0]        w_lifted;
    logic [COEFF_W-1:0] w_reduced;
    logic               w_unused_bits;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            eta3_q  <= 1'b0;
            word_q  <= '0;
            sub_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            eta3_q  <= eta3_d;
            word_q  <= word_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
        end
    end

    // Negative cbd results are lifted by Q; both lie below 2^COEFF_W.
    assign w_lifted      = ctrl_if.cbd_res_i + 32'(Q);
    assign w_reduced     = ctrl_if.cbd_res_i[31] ? w_lifted[COEFF_W-1:0]
                                                 : ctrl_if.cbd_res_i[COEFF_W-1:0];
    assign w_unused_bits = ^{w_lifted[31:COEFF_W], ctrl_if.cbd_res_i[30:COEFF_W]};
    assign w_last_slot   = eta3_q ? (sub_q == 3'd3) : (sub_q == 3'd7);

    always_comb begin
        state_d              = state_q;
        eta3_d               = eta3_q;
        word_d               = word_q;
        sub_d                = sub_q;
        idx_d                = idx_q;
        ctrl_if.busy_o       = 1'b0;
        ctrl_if.done_o       = 1'b0;
        ctrl_if.word_ready_o = 1'b0;
        ctrl_if.cbd_mode_o   = '0;
        ctrl_if.cbd_data_o   = '0;
        ctrl_if.coef_valid_o = 1'b0;
        ctrl_if.coef_o       = '0;
        ctrl_if.coef_idx_o   = '0;

        case (state_q)
            S_IDLE: begin
                if (ctrl_if.start_i) begin
                    eta3_d  = ctrl_if.eta3_i;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ctrl_if.busy_o       = 1'b1;
                ctrl_if.word_ready_o = 1'b1;
                if (ctrl_if.word_valid_i) begin
                    word_d  = ctrl_if.word_i;
                    sub_d   = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                ctrl_if.busy_o       = 1'b1;
                ctrl_if.coef_valid_o = 1'b1;
                ctrl_if.cbd_data_o   = word_q;
                ctrl_if.cbd_mode_o   = (eta3_q ? athos_pkg::CBD3_1 : athos_pkg::CBD2_1)
                                       + athos_pkg::funct7_t'(sub_q);
                ctrl_if.coef_o       = w_reduced;
                ctrl_if.coef_idx_o   = idx_q;
                if (ctrl_if.coef_ready_i) begin
                    idx_d = idx_q + 1'b1;
                    sub_d = sub_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else if (w_last_slot) begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                ctrl_if.done_o = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over start and both handshakes; the latched word is kept.
        if (ctrl_if.clear_i) begin
            state_d = S_IDLE;
            idx_d   = '0;
            sub_d   = '0;
            word_d  = word_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cbd_sampler_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cbd_sampler_ctrl
//  Brief    : Randomized self-checking bench for cbd_sampler_ctrl.
//  Revision : 1.0
// ============================================================================
module tb_cbd_sampler_ctrl;
    localparam int N  = 256;
    localparam int Q  = 3329;
    localparam int CW = 12;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    cbd_sampler_ctrl_if #(.N_COEFFS(N), .COEFF_W(CW)) ctrl_if ();

    cbd_sampler_ctrl #(.N_COEFFS(N), .Q(Q), .COEFF_W(CW)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .ctrl_if (ctrl_if)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] words_used[$];
    logic [31:0] preload[$];
    logic        ovr_en  = 1'b0;
    logic [31:0] ovr_val = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
        end
    endtask

    // Stand-in for the shared cbd unit: decodes the mode and pops bits of the operand.
    function automatic logic [31:0] cbd_unit(input logic [6:0] mode, input logic [31:0] d);
        int m = int'(mode);
        int r = 0;
        logic [31:0] s;
        if (m >= int'(athos_pkg::CBD2_1) && m < int'(athos_pkg::CBD2_1) + 8) begin
            s = d >> (4 * (m - int'(athos_pkg::CBD2_1)));
            r = int'(s[0]) + int'(s[1]) - int'(s[2]) - int'(s[3]);
        end else if (m >= int'(athos_pkg::CBD3_1) && m < int'(athos_pkg::CBD3_1) + 4) begin
            s = d >> (6 * (m - int'(athos_pkg::CBD3_1)));
            r = int'(s[0]) + int'(s[1]) + int'(s[2]) - int'(s[3]) - int'(s[4]) - int'(s[5]);
        end
        return 32'(r);
    endfunction

    always_comb ctrl_if.cbd_res_i = ovr_en ? ovr_val : cbd_unit(ctrl_if.cbd_mode_o, ctrl_if.cbd_data_o);

    // Reference: coefficient k of a polynomial = (popcount of first eta bits) minus
    // (popcount of next eta bits) of slot k%slots in word k/slots, lifted into [0,Q).
    function automatic int ref_coef(input bit eta3, input logic [31:0] w, input int sub);
        int e = eta3 ? 3 : 2;
        int a = 0;
        int b = 0;
        for (int i = 0; i < e; i++) begin
            a += int'(w[2*e*sub + i]);
            b += int'(w[2*e*sub + e + i]);
        end
        return (a - b < 0) ? (a - b + Q) : (a - b);
    endfunction

    task automatic idle_inputs();
        ctrl_if.start_i      = 1'b0;
        ctrl_if.clear_i      = 1'b0;
        ctrl_if.word_valid_i = 1'b0;
        ctrl_if.coef_ready_i = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"},  32'(ctrl_if.busy_o), 0);
        check_eq({tag, "_done"},  32'(ctrl_if.done_o), 0);
        check_eq({tag, "_wrdy"},  32'(ctrl_if.word_ready_o), 0);
        check_eq({tag, "_cval"},  32'(ctrl_if.coef_valid_o), 0);
        check_eq({tag, "_mode"},  32'(ctrl_if.cbd_mode_o), 0);
        check_eq({tag, "_data"},  ctrl_if.cbd_data_o, 0);
        check_eq({tag, "_coef"},  32'(ctrl_if.coef_o), 0);
        check_eq({tag, "_idx"},   32'(ctrl_if.coef_idx_o), 0);
    endtask

    task automatic run_poly(input bit eta3, input int gap_pct, input int bp_pct,
                            input int clear_at, input bit mid_start, input bit min_time,
                            input int hold_at);
        int          slots    = eta3 ? 4 : 8;
        int          coef_cnt = 0;
        int          wcnt     = 0;
        int          cyc      = 0;
        int          hold     = 0;
        int          k;
        int          dones    = 0;
        bit          done_seen = 0;
        bit          cleared   = 0;
        bit          prev_hs   = 0;
        logic [31:0] nxt;
        logic [31:0] w;
        words_used.delete();
        @(negedge clk_i);
        idle_inputs();
        ctrl_if.start_i = 1'b1;
        ctrl_if.eta3_i  = eta3;
        #1 check_eq("start_idle_busy", 32'(ctrl_if.busy_o), 0);
        nxt = (preload.size() > 0) ? preload.pop_front() : $urandom;
        while (!done_seen && !cleared && cyc < 5000) begin
            @(negedge clk_i);
            ctrl_if.start_i      = mid_start && (cyc == 40);
            ctrl_if.eta3_i       = mid_start ? ~eta3 : eta3;
            ctrl_if.word_valid_i = ($urandom_range(99) >= gap_pct);
            ctrl_if.word_i       = nxt;
            ctrl_if.coef_ready_i = ($urandom_range(99) >= bp_pct);
            if (hold_at >= 0 && coef_cnt == hold_at && hold < 3) begin
                ctrl_if.coef_ready_i = 1'b0;
                hold++;
            end
            ctrl_if.clear_i = (clear_at >= 0 && coef_cnt == clear_at);
            #1;
            if (cyc == 0) check_eq("start_to_wrdy", 32'(ctrl_if.word_ready_o), 1);
            if (prev_hs)  check_eq("word_to_cval", 32'(ctrl_if.coef_valid_o), 1);
            prev_hs = 0;
            if (ctrl_if.done_o) begin
                done_seen = 1;
                check_eq("done_busy",  32'(ctrl_if.busy_o), 0);
                check_eq("done_coefs", 32'(coef_cnt), 32'(N));
                check_eq("done_words", 32'(wcnt), 32'(N / slots));
                if (min_time) check_eq("min_cycles", 32'(cyc), 32'(N + N / slots));
            end else if (ctrl_if.clear_i) begin
                cleared = 1;
            end else begin
                if (ctrl_if.word_ready_o && ctrl_if.word_valid_i) begin
                    words_used.push_back(nxt);
                    wcnt++;
                    prev_hs = 1;
                    nxt = (preload.size() > 0) ? preload.pop_front() : $urandom;
                end
                if (ctrl_if.coef_valid_o) begin
                    k = coef_cnt;
                    w = (k / slots < words_used.size()) ? words_used[k / slots] : 32'hDEAD_BEEF;
                    check_eq("coef",  32'(ctrl_if.coef_o), 32'(ref_coef(eta3, w, k % slots)));
                    check_eq("idx",   32'(ctrl_if.coef_idx_o), 32'(k));
                    check_eq("mode",  32'(ctrl_if.cbd_mode_o),
                             32'(eta3 ? athos_pkg::CBD3_1 : athos_pkg::CBD2_1) + 32'(k % slots));
                    check_eq("data",  ctrl_if.cbd_data_o, w);
                    if (ctrl_if.coef_ready_i) coef_cnt++;
                end
            end
            cyc++;
        end
        @(negedge clk_i);
        idle_inputs();
        #1;
        if (cleared) begin
            check_quiet("clear");
            for (int i = 0; i < 20; i++) begin
                @(negedge clk_i);
                #1 if (ctrl_if.done_o) dones++;
            end
            check_eq("clear_no_done", 32'(dones), 0);
        end else begin
            check_eq("finished", 32'(done_seen), 1);
            check_eq("done_pulse_len", 32'(ctrl_if.done_o), 0);
            check_eq("after_done_busy", 32'(ctrl_if.busy_o), 0);
        end
    endtask

    task automatic reduce_test();
        int vals[4] = '{-7, 5, -1, -2};
        @(negedge clk_i);
        idle_inputs();
        ctrl_if.start_i = 1'b1;
        ctrl_if.eta3_i  = 1'b0;
        @(negedge clk_i);
        ctrl_if.start_i      = 1'b0;
        ctrl_if.word_valid_i = 1'b1;
        ctrl_if.word_i       = $urandom;
        @(negedge clk_i);
        ctrl_if.word_valid_i = 1'b0;
        ovr_en = 1'b1;
        ovr_val = 32'hFFFF_FFF9;
        #1 check_eq("reduce_m7", 32'(ctrl_if.coef_o), 3322);
        foreach (vals[i]) begin
            ovr_val = 32'(vals[i]);
            #1 check_eq("reduce", 32'(ctrl_if.coef_o), 32'((vals[i] < 0) ? vals[i] + Q : vals[i]));
        end
        ovr_en = 1'b0;
        @(negedge clk_i);
        ctrl_if.clear_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
    endtask

    task automatic async_reset_test();
        @(negedge clk_i);
        idle_inputs();
        ctrl_if.start_i = 1'b1;
        ctrl_if.eta3_i  = 1'b1;
        @(negedge clk_i);
        ctrl_if.start_i      = 1'b0;
        ctrl_if.word_valid_i = 1'b1;
        ctrl_if.word_i       = 32'h00FF_FFFF;
        @(negedge clk_i);
        ctrl_if.word_valid_i = 1'b0;
        #1 check_eq("pre_rst_cval", 32'(ctrl_if.coef_valid_o), 1);
        #2 rst_ni = 1'b0;
        #1 check_quiet("arst");
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        idle_inputs();
        ctrl_if.eta3_i = 1'b0;
        ctrl_if.word_i = '0;
        repeat (3) @(negedge clk_i);
        #1 check_quiet("reset");
        rst_ni = 1'b1;
        preload.push_back(32'h0000_001B);
        run_poly(1'b0, 0, 0, -1, 1'b0, 1'b1, -1);
        preload.push_back(32'hFF00_0038);
        preload.push_back(32'h0000_0001);
        run_poly(1'b1, 0, 0, -1, 1'b0, 1'b1, -1);
        run_poly(1'b0, 0, 0, -1, 1'b0, 1'b0, 2);
        run_poly(1'b0, 30, 20, -1, 1'b1, 1'b0, -1);
        run_poly(1'b1, 30, 20, -1, 1'b1, 1'b0, -1);
        reduce_test();
        run_poly(1'b0, 10, 10, 100, 1'b0, 1'b0, -1);
        run_poly(1'b1, 10, 10, -1, 1'b0, 1'b0, -1);
        async_reset_test();
        run_poly(1'b0, 20, 20, -1, 1'b0, 1'b0, -1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
